// File: rtl/pinaipple_acc_pkg.sv
// Shared types for the pinaipple memristor accelerator interface.
// Array opcodes, sequencer states and pad widths.
package pinaipple_acc_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    OP_INFER    = 2'b00,
    OP_READ_REG = 2'b01,
    OP_READ_MEM = 2'b10,
    OP_PROG     = 2'b11
  } array_op_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    RESP
  } seq_state_e;

endpackage

// File: rtl/pinaipple_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs.
// Each bit is synchronised independently.
module pinaipple_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pinaipple_array_seq.sv
// Pad timing sequencer for the memristor array.
// One command in flight: setup, pulse, hold, then respond.
module pinaipple_array_seq
  import pinaipple_acc_pkg::*;
#(
  parameter int TSetup = 4,
  parameter int TPulse = 8,
  parameter int THold  = 4,
  parameter int AddrW  = ADDR_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [AddrW-1:0] cmd_col_i,
  input  logic [AddrW-1:0] cmd_row_i,
  input  logic             cmd_wbit_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [3:0]       rsp_data_o,
  output logic             busy_o,
  output logic [1:0]       instructions_o,
  output logic [AddrW-1:0] addr_col_o,
  output logic [AddrW-1:0] addr_row_o,
  output logic             cbl_o,
  output logic             cblen_o,
  output logic             csl_o,
  output logic             cwl_o,
  input  logic             bit_out_i [DATA_W]
);

  localparam int MaxSP = (TSetup > TPulse) ? TSetup : TPulse;
  localparam int MaxT  = (MaxSP > THold) ? MaxSP : THold;
  localparam int CntW  = (MaxT > 1) ? $clog2(MaxT) : 1;

  if (TSetup < 1 || TPulse < 1 || THold < 3) begin : g_param_chk
    $error("pinaipple_array_seq: illegal timing parameters");
  end

  seq_state_e state_q, state_d;
  array_op_e  op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [AddrW-1:0]  col_q, col_d;
  logic [AddrW-1:0]  row_q, row_d;
  logic              wbit_q, wbit_d;
  logic [DATA_W-1:0] data_q, data_d;
  // {cbl, cblen, csl, cwl}, registered so pads never glitch
  logic [3:0]        ctl_q, ctl_d;
  logic [DATA_W-1:0] bits_raw;
  logic [DATA_W-1:0] bits_sync;

  always_comb begin
    for (int i = 0; i < DATA_W; i++) begin
      bits_raw[i] = bit_out_i[i];
    end
  end

  pinaipple_sync2 #(
    .W(DATA_W)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (bits_raw),
    .q_o  (bits_sync)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= OP_INFER;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wbit_q  <= 1'b0;
      data_q  <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wbit_q  <= wbit_d;
      data_q  <= data_d;
      ctl_q   <= ctl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    wbit_d  = wbit_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = SETUP;
          cnt_d   = CntW'(TSetup - 1);
          op_d    = array_op_e'(cmd_op_i);
          col_d   = cmd_col_i;
          row_d   = cmd_row_i;
          wbit_d  = cmd_wbit_i;
        end
      end
      SETUP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (op_q == OP_READ_REG) begin
          state_d = HOLD;
          cnt_d   = CntW'(THold - 1);
        end else begin
          state_d = PULSE;
          cnt_d   = CntW'(TPulse - 1);
        end
      end
      PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = HOLD;
          cnt_d   = CntW'(THold - 1);
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RESP;
          data_d  = (op_q == OP_PROG) ? '0 : bits_sync;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          op_d    = OP_INFER;
          col_d   = '0;
          row_d   = '0;
          wbit_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctl_d = '0;
    if (state_d == PULSE) begin
      unique case (1'b1)
        (op_d == OP_PROG):     ctl_d = {wbit_d, 1'b1, ~wbit_d, 1'b1};
        (op_d == OP_READ_MEM): ctl_d = 4'b0011;
        (op_d == OP_INFER):    ctl_d = 4'b0010;
        default:               ctl_d = '0;
      endcase
    end
  end

  assign cmd_ready_o    = (state_q == IDLE) && !rst_i;
  assign busy_o         = (state_q != IDLE);
  assign rsp_valid_o    = (state_q == RESP);
  assign rsp_data_o     = data_q;
  assign instructions_o = op_q;
  assign addr_col_o     = col_q;
  assign addr_row_o     = row_q;
  assign {cbl_o, cblen_o, csl_o, cwl_o} = ctl_q;

  a_ctl_pulse_only: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (state_q != PULSE) |-> (ctl_q == 4'b0)
  );

endmodule

// File: tb/tb_pinaipple_array_seq.sv
// Directed bench for the pinaipple array sequencer.
// Cycle 0 is the handshake cycle; cycle k follows k clock edges.
module tb_pinaipple_array_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [4:0] cmd_col = '0;
  logic [4:0] cmd_row = '0;
  logic       cmd_wbit = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_data;
  logic       busy;
  logic [1:0] instr;
  logic [4:0] acol;
  logic [4:0] arow;
  logic       cbl, cblen, csl, cwl;
  logic       bit_out [4];

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pinaipple_array_seq dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_op_i      (cmd_op),
    .cmd_col_i     (cmd_col),
    .cmd_row_i     (cmd_row),
    .cmd_wbit_i    (cmd_wbit),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_data_o    (rsp_data),
    .busy_o        (busy),
    .instructions_o(instr),
    .addr_col_o    (acol),
    .addr_row_o    (arow),
    .cbl_o         (cbl),
    .cblen_o       (cblen),
    .csl_o         (csl),
    .cwl_o         (cwl),
    .bit_out_i     (bit_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_bits(input logic [3:0] v);
    for (int i = 0; i < 4; i++) bit_out[i] = v[i];
  endtask

  function automatic logic [3:0] ctl();
    return {cbl, cblen, csl, cwl};
  endfunction

  // Issue from a negedge in IDLE; returns at the negedge of the
  // first rsp_valid cycle (or after the cycle budget expires).
  task automatic do_cmd(
    input  logic [1:0] op,
    input  logic [4:0] col,
    input  logic [4:0] row,
    input  logic       wbit,
    input  int         chg_cyc,
    input  logic [3:0] chg_val,
    output int         rsp_cyc,
    output int         p_start,
    output int         p_len,
    output logic [3:0] pat,
    output bit         pat_ok,
    output bit         ia_ok,
    output logic [3:0] data
  );
    logic [3:0] c;
    cmd_op    = op;
    cmd_col   = col;
    cmd_row   = row;
    cmd_wbit  = wbit;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    rsp_cyc = -1;
    p_start = -1;
    p_len   = 0;
    pat     = '0;
    pat_ok  = 1'b1;
    ia_ok   = 1'b1;
    data    = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == chg_cyc) set_bits(chg_val);
      if (instr !== op || acol !== col || arow !== row) ia_ok = 1'b0;
      c = ctl();
      if (c != 4'b0) begin
        if (p_start < 0) begin
          p_start = k;
          pat     = c;
        end else if (c != pat) begin
          pat_ok = 1'b0;
        end
        p_len++;
      end
      if (rsp_valid === 1'b1) begin
        rsp_cyc = k;
        data    = rsp_data;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  int         rc, ps, pl;
  logic [3:0] pt, dt;
  bit         pok, iok;
  int         seen;

  initial begin
    set_bits(4'b0000);
    #2;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", rsp_valid, 0);
    chk("rst_pads", {instr, acol, arow, ctl()}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);

    // Program, wbit=1; pad data must be ignored
    set_bits(4'b1111);
    do_cmd(2'b11, 5'd5, 5'd17, 1'b1, 0, 4'b0,
           rc, ps, pl, pt, pok, iok, dt);
    chk("prog_pstart", ps, 5);
    chk("prog_plen", pl, 8);
    chk("prog_pat", pt, 4'b1101);
    chk("prog_patok", pok, 1);
    chk("prog_ia", iok, 1);
    chk("prog_rcyc", rc, 17);
    chk("prog_data", dt, 0);
    @(negedge clk);
    chk("prog_idle_ready", cmd_ready, 1);
    chk("prog_idle_pads", {instr, acol, arow}, 0);

    // Program, wbit=0
    do_cmd(2'b11, 5'd1, 5'd2, 1'b0, 0, 4'b0,
           rc, ps, pl, pt, pok, iok, dt);
    chk("prog0_pat", pt, 4'b0111);
    chk("prog0_plen", pl, 8);
    @(negedge clk);

    // Read memory
    set_bits(4'b1010);
    do_cmd(2'b10, 5'd31, 5'd0, 1'b0, 0, 4'b0,
           rc, ps, pl, pt, pok, iok, dt);
    chk("rdm_pstart", ps, 5);
    chk("rdm_plen", pl, 8);
    chk("rdm_pat", pt, 4'b0011);
    chk("rdm_ia", iok, 1);
    chk("rdm_rcyc", rc, 17);
    chk("rdm_data", dt, 4'b1010);
    @(negedge clk);

    // Read register: no pulse at all
    set_bits(4'b0110);
    do_cmd(2'b01, 5'd9, 5'd3, 1'b0, 0, 4'b0,
           rc, ps, pl, pt, pok, iok, dt);
    chk("rdr_plen", pl, 0);
    chk("rdr_rcyc", rc, 9);
    chk("rdr_data", dt, 4'b0110);
    @(negedge clk);

    // Pad change in the last HOLD cycle is too late to capture
    set_bits(4'b1100);
    do_cmd(2'b10, 5'd3, 5'd9, 1'b0, 16, 4'b0011,
           rc, ps, pl, pt, pok, iok, dt);
    chk("late_rcyc", rc, 17);
    chk("late_data", dt, 4'b1100);
    @(negedge clk);

    // Inference with response back-pressure and a queued command
    set_bits(4'b1001);
    rsp_ready = 1'b0;
    do_cmd(2'b00, 5'd7, 5'd12, 1'b0, 0, 4'b0,
           rc, ps, pl, pt, pok, iok, dt);
    chk("inf_pat", pt, 4'b0010);
    chk("inf_plen", pl, 8);
    chk("inf_rcyc", rc, 17);
    chk("inf_data", dt, 4'b1001);
    cmd_op    = 2'b01;
    cmd_col   = 5'd1;
    cmd_row   = 5'd2;
    cmd_valid = 1'b1;
    set_bits(4'b0101);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("inf_hold_valid", rsp_valid, 1);
      chk("inf_hold_data", rsp_data, 4'b1001);
      chk("inf_hold_ready", cmd_ready, 0);
      chk("inf_hold_addr", {acol, arow}, {5'd7, 5'd12});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("pend_idle_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("pend_busy", busy, 1);
    chk("pend_ia", {instr, acol, arow}, {2'b01, 5'd1, 5'd2});
    rc = -1;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        rc = k;
        break;
      end
    end
    chk("pend_rcyc", rc, 9);
    chk("pend_data", rsp_data, 4'b0101);
    @(negedge clk);

    // Reset in the middle of a programming pulse
    cmd_op    = 2'b11;
    cmd_col   = 5'd5;
    cmd_row   = 5'd17;
    cmd_wbit  = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("mid_pulse_cwl", cwl, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pads", {instr, acol, arow, ctl()}, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk("post_rst_quiet", seen, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
